// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: bus command codes, I/O address map and debounce FSM
// encodings shared by mmio_bridge and key_debounce.
package mmio_bridge_pkg;

    // CPU memory bus commands
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // I/O register addresses (mem_addr[8] = 1 selects the I/O page)
    localparam logic [8:0] ADDR_LED    = 9'h100;
    localparam logic [8:0] ADDR_SW     = 9'h140;
    localparam logic [8:0] ADDR_KEYEVT = 9'h141;
    localparam logic [8:0] ADDR_TICK   = 9'h142;

    // Debouncer states
    typedef enum logic [1:0] {
        DEB_UP        = 2'd0,
        DEB_WAIT_DOWN = 2'd1,
        DEB_DOWN      = 2'd2,
        DEB_WAIT_UP   = 2'd3
    } deb_state_t;

    // Lower half of the address space is RAM
    function automatic logic addr_is_ram(input logic [8:0] addr);
        return ~addr[8];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer for one active-low key, followed by a
// four-state debouncer. o_press pulses for one cycle when a press is
// accepted; releases produce no pulse. o_state exposes the FSM state.
module key_debounce
    import mmio_bridge_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_n,
    output logic       o_press,
    output logic [1:0] o_state
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          w_sample;
    deb_state_t    r_state;
    deb_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_last;
    logic          w_cnt_clr;
    logic          w_cnt_inc;

    // Synchronize the raw key; reset value 1 means "released"
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_key_n};
    end

    assign w_sample   = r_sync[1];
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= DEB_UP;
        else       r_state <= w_next;
    end

    // Next-state: a level must hold DEB_CYCLES samples in a WAIT state
    always_comb begin
        w_next = r_state;
        case (r_state)
            DEB_UP:        if (!w_sample) w_next = DEB_WAIT_DOWN;
            DEB_WAIT_DOWN: if (w_sample) w_next = DEB_UP;
                           else if (w_cnt_last) w_next = DEB_DOWN;
            DEB_DOWN:      if (w_sample) w_next = DEB_WAIT_UP;
            DEB_WAIT_UP:   if (!w_sample) w_next = DEB_DOWN;
                           else if (w_cnt_last) w_next = DEB_UP;
            default:       w_next = DEB_UP;
        endcase
    end

    // Outputs: counter control and the one-cycle press pulse
    always_comb begin
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        o_press   = 1'b0;
        case (r_state)
            DEB_UP:        w_cnt_clr = ~w_sample;
            DEB_WAIT_DOWN: begin
                w_cnt_inc = ~w_sample & ~w_cnt_last;
                o_press   = ~w_sample & w_cnt_last;
            end
            DEB_DOWN:      w_cnt_clr = w_sample;
            DEB_WAIT_UP:   w_cnt_inc = w_sample & ~w_cnt_last;
            default:       w_cnt_clr = 1'b1;
        endcase
    end

    // Stable-sample counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_cnt <= '0;
        else if (w_cnt_clr) r_cnt <= '0;
        else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
    end

    assign o_state = r_state;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the 9-bit CPU bus address into RAM and I/O registers
// (LED, synchronized switches, clear-on-read key events, tick counter) and
// returns a single combinational read mux.
// Optional tick counter at 0x142 is built when MMIO_BRIDGE_TICK_EN is defined;
// otherwise 0x142 behaves as an unmapped address.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int TICK_DIV   = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] wdata,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    input  logic [1:0]  key_n,
    output logic [15:0] rdata,
    output logic        ram_write,
    output logic [7:0]  ledr
);

    logic [7:0]  r_ledr;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [1:0]  r_evt;
    logic        r_rd_evt_q;
    logic        w_rd_evt;
    logic        w_evt_clr;
    logic [1:0]  w_press;
    logic [1:0]  w_key0_state;
    logic [1:0]  w_key1_state;
    logic [15:0] w_tick_rdata;
    logic        w_wr_led;

    assign ram_write = (mem_cmd == MWRITE) & addr_is_ram(mem_addr);
    assign w_wr_led  = (mem_cmd == MWRITE) & (mem_addr == ADDR_LED);
    assign ledr      = r_ledr;

    // LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_ledr <= 8'h00;
        else if (w_wr_led) r_ledr <= wdata[7:0];
    end

    // Two-flop switch synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key0 (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_key_n (key_n[0]),
        .o_press (w_press[0]),
        .o_state (w_key0_state)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key1 (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_key_n (key_n[1]),
        .o_press (w_press[1]),
        .o_state (w_key1_state)
    );

    // Debounce state is kept on the sub-module ports for observation only
    logic w_unused_dbg;
    assign w_unused_dbg = ^{w_key0_state, w_key1_state};

    // Event flags clear when a KEYEVT read ends, so a multi-cycle read
    // sees a stable value; a same-cycle press wins over the clear.
    assign w_rd_evt  = (mem_cmd == MREAD) & (mem_addr == ADDR_KEYEVT);
    assign w_evt_clr = r_rd_evt_q & ~w_rd_evt;

    // Read-end detector and sticky key event flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_evt_q <= 1'b0;
            r_evt      <= 2'b00;
        end else begin
            r_rd_evt_q <= w_rd_evt;
            r_evt      <= (r_evt & ~{2{w_evt_clr}}) | w_press;
        end
    end

`ifdef MMIO_BRIDGE_TICK_EN
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [15:0]   r_tick;
    logic          w_wr_tick;

    assign w_wr_tick    = (mem_cmd == MWRITE) & (mem_addr == ADDR_TICK);
    assign w_tick_rdata = r_tick;

    // Prescaler and tick counter; a CPU write overrides the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 16'h0000;
        end else if (w_wr_tick) begin
            r_presc <= '0;
            r_tick  <= wdata;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_tick  <= r_tick + 16'h0001;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end
`else
    assign w_tick_rdata = 16'h0000;

    // Upper write-data bits and TICK_DIV only matter when the tick exists
    logic w_unused_tick;
    assign w_unused_tick = (^wdata[15:8]) ^ (TICK_DIV == 0);
`endif

    // Read mux; anything not explicitly mapped returns zero
    always_comb begin
        rdata = 16'h0000;
        if (mem_cmd == MREAD) begin
            if (addr_is_ram(mem_addr)) begin
                rdata = ram_dout;
            end else begin
                case (mem_addr)
                    ADDR_LED:    rdata = {8'h00, r_ledr};
                    ADDR_SW:     rdata = {8'h00, r_sw_sync};
                    ADDR_KEYEVT: rdata = {14'h0000, r_evt};
                    ADDR_TICK:   rdata = w_tick_rdata;
                    default:     rdata = 16'h0000;
                endcase
            end
        end
    end

endmodule
